// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the fetch PC, issues word reads under a credit limit, buffers
// returned words with their PCs and hands them to decode; redirects flush and restart fetch.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_fault
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      fetch_pc_reg, fetch_pc_next;
    logic             fault_reg, fault_next;
    logic [CNT_W-1:0] inflight_reg, inflight_next;
    logic [CNT_W-1:0] drop_reg, drop_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] tag_count_reg, tag_count_next;
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [PTR_W-1:0] tag_head_reg, tag_head_next;
    logic [PTR_W-1:0] tag_tail_reg, tag_tail_next;

    logic [31:0] buf_data_mem [BUF_DEPTH];
    logic [31:0] buf_pc_mem   [BUF_DEPTH];
    logic [31:0] tag_mem      [BUF_DEPTH];

    logic credit_ok;
    logic issue_en;
    logic req_fire;
    logic rsp_retire;
    logic rsp_drop;
    logic rsp_take;
    logic pop;
    logic target_aligned;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Words still in flight count against the buffer so every response has a free slot.
    assign credit_ok      = ({1'b0, inflight_reg} + {1'b0, count_reg}) < DEPTH_EXT;
    assign issue_en       = !reset && (state_reg == ST_RUN) && !redirect_valid && credit_ok;
    assign imem_req_valid = issue_en;
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = issue_en && imem_req_ready;

    assign rsp_retire     = imem_rsp_valid && (inflight_reg != '0);
    assign rsp_drop       = rsp_retire && (drop_reg != '0);
    assign rsp_take       = rsp_retire && (drop_reg == '0) && (tag_count_reg != '0) && !redirect_valid;

    assign inst_valid     = (count_reg != '0);
    assign pop            = inst_valid && inst_ready;
    assign inst_data      = inst_valid ? buf_data_mem[head_reg] : '0;
    assign inst_pc        = inst_valid ? buf_pc_mem[head_reg]   : '0;
    assign misalign_fault = fault_reg;
    assign target_aligned = (redirect_pc[1:0] == 2'b00);

    always_comb begin
        state_next     = state_reg;
        fetch_pc_next  = fetch_pc_reg;
        fault_next     = fault_reg;
        drop_next      = drop_reg;
        head_next      = head_reg;
        tail_next      = tail_reg;
        tag_head_next  = tag_head_reg;
        tag_tail_next  = tag_tail_reg;
        inflight_next  = inflight_reg + CNT_W'(req_fire) - CNT_W'(rsp_retire);
        tag_count_next = tag_count_reg + CNT_W'(req_fire) - CNT_W'(rsp_take);
        count_next     = count_reg + CNT_W'(rsp_take) - CNT_W'(pop);

        if (rsp_drop) begin
            drop_next = drop_reg - CNT_W'(1);
        end
        if (req_fire) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
            tag_tail_next = ptr_inc(tag_tail_reg);
        end
        if (rsp_take) begin
            tail_next     = ptr_inc(tail_reg);
            tag_head_next = ptr_inc(tag_head_reg);
        end
        if (pop) begin
            head_next = ptr_inc(head_reg);
        end

        // Everything still in flight after this cycle's accounting belongs to the old path.
        if (redirect_valid) begin
            count_next     = '0;
            head_next      = '0;
            tail_next      = '0;
            tag_count_next = '0;
            tag_head_next  = '0;
            tag_tail_next  = '0;
            drop_next      = inflight_next;
            if (target_aligned) begin
                fetch_pc_next = redirect_pc;
                fault_next    = 1'b0;
                state_next    = ST_RUN;
            end else begin
                fault_next    = 1'b1;
                state_next    = ST_FAULT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            fetch_pc_reg  <= RESET_PC;
            fault_reg     <= 1'b0;
            inflight_reg  <= '0;
            drop_reg      <= '0;
            count_reg     <= '0;
            tag_count_reg <= '0;
            head_reg      <= '0;
            tail_reg      <= '0;
            tag_head_reg  <= '0;
            tag_tail_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            fetch_pc_reg  <= fetch_pc_next;
            fault_reg     <= fault_next;
            inflight_reg  <= inflight_next;
            drop_reg      <= drop_next;
            count_reg     <= count_next;
            tag_count_reg <= tag_count_next;
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            tag_head_reg  <= tag_head_next;
            tag_tail_reg  <= tag_tail_next;
        end
    end

    // Storage needs no reset: occupancy counters decide what is visible.
    always_ff @(posedge clk) begin
        if (rsp_take && !reset) begin
            buf_data_mem[tail_reg] <= imem_rsp_data;
            buf_pc_mem[tail_reg]   <= tag_mem[tag_head_reg];
        end
        if (req_fire) begin
            tag_mem[tag_tail_reg] <= fetch_pc_reg;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural in-order instruction ROM with programmable
// latency, a delivery recorder, and one task per scenario with inline checks.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_fault;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat = 1;
    int acc_count = 0;
    int first_acc_cyc = -1;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] dl_pc[$];
    logic [31:0] dl_data[$];
    int          dl_cyc[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_fault (misalign_fault)
    );

    // ROM contents: addi x0,x0,<addr[11:0]>, so address 0 holds 0x00000013.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[11:0], 20'h00013};
    endfunction

    // Edge-time bookkeeping: accepted requests and decode handshakes.
    always @(posedge clk) begin
        if (reset) begin
            q_addr.delete();
            q_due.delete();
        end else begin
            if (inst_valid && inst_ready && !redirect_valid) begin
                dl_pc.push_back(inst_pc);
                dl_data.push_back(inst_data);
                dl_cyc.push_back(cyc);
            end
            if (imem_req_valid && imem_req_ready) begin
                if (acc_count == 0) first_acc_cyc = cyc;
                acc_count++;
                q_addr.push_back(imem_req_addr);
                q_due.push_back(cyc + lat);
            end
        end
        cyc++;
    end

    // Responses are presented mid-cycle and sampled at the following rising edge.
    always @(negedge clk) begin
        if (!reset && q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input int lat_v, input logic ready_v);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = ready_v;
        lat            = lat_v;
        tick();
        tick();
        dl_pc.delete();
        dl_data.delete();
        dl_cyc.delete();
        acc_count     = 0;
        first_acc_cyc = -1;
        reset         = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b1;
        lat            = 1;
        tick();
        tick();
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %0b want 0", imem_req_valid); end
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_inst_valid: got %0b want 0", inst_valid); end
        vectors++; if (inst_data !== 32'h0) begin miscompares++; $display("FAIL reset_inst_data: got %08h want 00000000", inst_data); end
        vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL reset_inst_pc: got %08h want 00000000", inst_pc); end
        vectors++; if (misalign_fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %0b want 0", misalign_fault); end
        dl_pc.delete(); dl_data.delete(); dl_cyc.delete();
        acc_count = 0;
        first_acc_cyc = -1;
        reset = 1'b0;
        #1;
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL release_req_valid: got %0b want 1", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL release_req_addr: got %08h want 00000000", imem_req_addr); end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        for (int i = 0; i < 40 && dl_pc.size() < 3; i++) tick();
        vectors++;
        if (dl_pc.size() < 3) begin
            miscompares++; $display("FAIL stream_timeout: got %0d words want 3", dl_pc.size());
            return;
        end
        vectors++; if (dl_pc[0] !== 32'h0) begin miscompares++; $display("FAIL stream_pc0: got %08h want 00000000", dl_pc[0]); end
        vectors++; if (dl_pc[1] !== 32'h4) begin miscompares++; $display("FAIL stream_pc1: got %08h want 00000004", dl_pc[1]); end
        vectors++; if (dl_pc[2] !== 32'h8) begin miscompares++; $display("FAIL stream_pc2: got %08h want 00000008", dl_pc[2]); end
        vectors++; if (dl_data[0] !== 32'h00000013) begin miscompares++; $display("FAIL stream_data0: got %08h want 00000013", dl_data[0]); end
        vectors++; if (dl_data[1] !== 32'h00400013) begin miscompares++; $display("FAIL stream_data1: got %08h want 00400013", dl_data[1]); end
        vectors++; if (dl_data[2] !== 32'h00800013) begin miscompares++; $display("FAIL stream_data2: got %08h want 00800013", dl_data[2]); end
        vectors++; if (dl_cyc[0] - first_acc_cyc !== 2) begin miscompares++; $display("FAIL stream_latency: got %0d cycles want 2", dl_cyc[0] - first_acc_cyc); end
        $display("test_stream done: pcs %08h %08h %08h", dl_pc[0], dl_pc[1], dl_pc[2]);
    endtask

    task automatic test_backpressure();
        start(1, 1'b0);
        repeat (10) tick();
        vectors++; if (acc_count !== 2) begin miscompares++; $display("FAIL bp_requests: got %0d want 2", acc_count); end
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_req_valid: got %0b want 0", imem_req_valid); end
        vectors++; if (inst_valid !== 1'b1) begin miscompares++; $display("FAIL bp_inst_valid: got %0b want 1", inst_valid); end
        vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL bp_inst_pc_held: got %08h want 00000000", inst_pc); end
        vectors++; if (inst_data !== 32'h00000013) begin miscompares++; $display("FAIL bp_inst_data_held: got %08h want 00000013", inst_data); end
        vectors++; if (dl_pc.size() !== 0) begin miscompares++; $display("FAIL bp_no_delivery: got %0d want 0", dl_pc.size()); end
        inst_ready = 1'b1;
        for (int i = 0; i < 40 && dl_pc.size() < 4; i++) tick();
        vectors++;
        if (dl_pc.size() < 4) begin
            miscompares++; $display("FAIL bp_timeout: got %0d words want 4", dl_pc.size());
            return;
        end
        vectors++; if (dl_pc[0] !== 32'h0) begin miscompares++; $display("FAIL bp_pc0: got %08h want 00000000", dl_pc[0]); end
        vectors++; if (dl_pc[1] !== 32'h4) begin miscompares++; $display("FAIL bp_pc1: got %08h want 00000004", dl_pc[1]); end
        vectors++; if (dl_pc[2] !== 32'h8) begin miscompares++; $display("FAIL bp_pc2: got %08h want 00000008", dl_pc[2]); end
        vectors++; if (dl_pc[3] !== 32'hC) begin miscompares++; $display("FAIL bp_pc3: got %08h want 0000000c", dl_pc[3]); end
        $display("test_backpressure done");
    endtask

    task automatic test_redirect_inflight();
        int base;
        bit found;
        start(3, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (dl_pc.size() >= 2 && q_addr.size() == 2 && !imem_rsp_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL redir_setup_timeout: got no two-in-flight window want one");
            return;
        end
        base = dl_pc.size();
        $display("redirect to 00000008 with %08h %08h in flight", q_addr[0], q_addr[1]);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        tick();
        redirect_valid = 1'b0;
        #1;
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush: got inst_valid %0b want 0", inst_valid); end
        vectors++; if (imem_req_addr !== 32'h8) begin miscompares++; $display("FAIL redir_fetch_pc: got %08h want 00000008", imem_req_addr); end
        for (int i = 0; i < 60 && dl_pc.size() < base + 2; i++) tick();
        vectors++;
        if (dl_pc.size() < base + 2) begin
            miscompares++; $display("FAIL redir_timeout: got %0d words want %0d", dl_pc.size(), base + 2);
            return;
        end
        vectors++; if (dl_pc[base] !== 32'h8) begin miscompares++; $display("FAIL redir_pc_first: got %08h want 00000008", dl_pc[base]); end
        vectors++; if (dl_data[base] !== 32'h00800013) begin miscompares++; $display("FAIL redir_data_first: got %08h want 00800013", dl_data[base]); end
        vectors++; if (dl_pc[base+1] !== 32'hC) begin miscompares++; $display("FAIL redir_pc_second: got %08h want 0000000c", dl_pc[base+1]); end
        $display("test_redirect_inflight done");
    endtask

    task automatic test_redirect_same_cycle();
        int base;
        bit found;
        start(1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_rsp_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL same_setup_timeout: got no response want one");
            return;
        end
        base = dl_pc.size();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        #1;
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL same_discard: got inst_valid %0b want 0", inst_valid); end
        for (int i = 0; i < 40 && dl_pc.size() < base + 2; i++) tick();
        vectors++;
        if (dl_pc.size() < base + 2) begin
            miscompares++; $display("FAIL same_timeout: got %0d words want %0d", dl_pc.size(), base + 2);
            return;
        end
        vectors++; if (dl_pc[base] !== 32'h10) begin miscompares++; $display("FAIL same_pc_first: got %08h want 00000010", dl_pc[base]); end
        vectors++; if (dl_data[base] !== 32'h01000013) begin miscompares++; $display("FAIL same_data_first: got %08h want 01000013", dl_data[base]); end
        vectors++; if (dl_pc[base+1] !== 32'h14) begin miscompares++; $display("FAIL same_pc_second: got %08h want 00000014", dl_pc[base+1]); end
        $display("test_redirect_same_cycle done");
    endtask

    task automatic test_misalign();
        int acc_before;
        int dl_before;
        start(1, 1'b1);
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        tick();
        redirect_valid = 1'b0;
        #1;
        vectors++; if (misalign_fault !== 1'b1) begin miscompares++; $display("FAIL mis_fault_set: got %0b want 1", misalign_fault); end
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL mis_no_req: got %0b want 0", imem_req_valid); end
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL mis_flush: got %0b want 0", inst_valid); end
        vectors++; if (imem_req_addr !== 32'hC) begin miscompares++; $display("FAIL mis_pc_kept: got %08h want 0000000c", imem_req_addr); end
        acc_before = acc_count;
        dl_before  = dl_pc.size();
        repeat (5) tick();
        vectors++; if (acc_count !== acc_before) begin miscompares++; $display("FAIL mis_halted_reqs: got %0d want %0d", acc_count, acc_before); end
        vectors++; if (dl_pc.size() !== dl_before) begin miscompares++; $display("FAIL mis_halted_words: got %0d want %0d", dl_pc.size(), dl_before); end
        vectors++; if (misalign_fault !== 1'b1) begin miscompares++; $display("FAIL mis_fault_sticky: got %0b want 1", misalign_fault); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick();
        redirect_valid = 1'b0;
        #1;
        vectors++; if (misalign_fault !== 1'b0) begin miscompares++; $display("FAIL mis_fault_clear: got %0b want 0", misalign_fault); end
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL mis_restart_valid: got %0b want 1", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h10) begin miscompares++; $display("FAIL mis_restart_addr: got %08h want 00000010", imem_req_addr); end
        for (int i = 0; i < 40 && dl_pc.size() < dl_before + 1; i++) tick();
        vectors++;
        if (dl_pc.size() < dl_before + 1) begin
            miscompares++; $display("FAIL mis_timeout: got %0d words want %0d", dl_pc.size(), dl_before + 1);
            return;
        end
        vectors++; if (dl_pc[dl_before] !== 32'h10) begin miscompares++; $display("FAIL mis_restart_pc: got %08h want 00000010", dl_pc[dl_before]); end
        $display("test_misalign done");
    endtask

    task automatic test_reset_midflight();
        bit found;
        start(3, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (inst_valid && (q_addr.size() > 0 || imem_rsp_valid)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL rst_setup_timeout: got no busy state want one");
            return;
        end
        reset = 1'b1;
        tick();
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL rst_inst_valid: got %0b want 0", inst_valid); end
        vectors++; if (inst_data !== 32'h0) begin miscompares++; $display("FAIL rst_inst_data: got %08h want 00000000", inst_data); end
        vectors++; if (inst_pc !== 32'h0) begin miscompares++; $display("FAIL rst_inst_pc: got %08h want 00000000", inst_pc); end
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %0b want 0", imem_req_valid); end
        vectors++; if (misalign_fault !== 1'b0) begin miscompares++; $display("FAIL rst_fault: got %0b want 0", misalign_fault); end
        dl_pc.delete(); dl_data.delete(); dl_cyc.delete();
        reset      = 1'b0;
        inst_ready = 1'b1;
        #1;
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL rst_restart_valid: got %0b want 1", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL rst_restart_addr: got %08h want 00000000", imem_req_addr); end
        for (int i = 0; i < 40 && dl_pc.size() < 1; i++) tick();
        vectors++;
        if (dl_pc.size() < 1) begin
            miscompares++; $display("FAIL rst_timeout: got %0d words want 1", dl_pc.size());
            return;
        end
        vectors++; if (dl_pc[0] !== 32'h0) begin miscompares++; $display("FAIL rst_first_pc: got %08h want 00000000", dl_pc[0]); end
        vectors++; if (dl_data[0] !== 32'h00000013) begin miscompares++; $display("FAIL rst_first_data: got %08h want 00000013", dl_data[0]); end
        $display("test_reset_midflight done");
    endtask

    initial begin
        reset          = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_misalign();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
